// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - start/operand/result bundle for the bit-serial add/sub engine
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around a single full-adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s, fa_c;

  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        // subtraction is a + ~b + 1, the +1 entering as the initial carry
        a_sh    <= bus.a;
        b_sh    <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub;
        cnt     <= '0;
      end else if (state_q == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        s_sh    <= {fa_s, s_sh[WIDTH-1:1]};
        carry_q <= fa_c;
        cnt     <= cnt + CW'(1);
        if (last) begin
          // carry_q here is the carry into the MSB
          result_q <= {fa_s, s_sh[WIDTH-1:1]};
          cout_q   <= fa_c;
          ovf_q    <= carry_q ^ fa_c;
        end
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract engine that time-multiplexes a single `fulladder` cell over a WIDTH-bit operand pair, one bit per clock. It holds the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It sits beside the full-adder datapath as its sequencer, so wide additions run without replicating the adder cell.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range is WIDTH ≥ 2.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result fields valid.
- `result`  out  WIDTH  sum/difference, registered.
- `cout`  out  1  carry out of MSB; for sub, 1 = no borrow.
- `ovf`  out  1  two's-complement overflow.

## Operation
- One instance of `fulladder` is used. Its inputs are `a_sh[0]`, `b_sh[0]` and `carry_q`. Its outputs are the sum bit and the next carry.
- The FSM has three states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - With `start` = 1, load `a_sh` ← a.
  - Load `b_sh` ← (sub ? ~b : b).
  - Load `carry_q` ← sub.
  - Set `cnt` ← 0 and go to RUN.
  - With `start` = 0, stay in IDLE.
- RUN, each cycle:
  - `a_sh` and `b_sh` shift right by 1.
  - The sum bit enters the MSB of the internal `s_sh`, which shifts right.
  - `carry_q` ← FA carry.
  - `cnt` ← `cnt` + 1.
  - When `cnt` = WIDTH−1, record `c_msb_in` ← `carry_q`, which is the carry into the MSB.
  - After the cycle with `cnt` = WIDTH−1, go to DONE.
- On entry to DONE, the registers update:
  - `result` ← final `s_sh`, including the bit of the last cycle.
  - `cout` ← final carry.
  - `ovf` ← `c_msb_in` XOR final carry.
- DONE lasts exactly one cycle, with `done` = 1.
  - With `start` = 1, it behaves like IDLE with `start` (load operands, go to RUN). This allows back-to-back operations.
  - Otherwise, go to IDLE.
- `start` in RUN is ignored. No queuing: the operation in flight is unaffected.
- `result`, `cout` and `ovf` change only on DONE entry. They hold their values through IDLE and the following RUN until the next DONE entry.
- `busy` is 1 exactly in RUN. `done` is 1 exactly in DONE. `busy` and `done` are never high together.
- `cnt` width is $clog2(WIDTH). The counter never wraps in normal operation, because the RUN exit occurs at WIDTH−1.
- Reset (`rst_n` = 0 at an edge) takes effect in any state, including mid-RUN:
  - The FSM goes to IDLE.
  - `busy`, `done`, `result`, `cout`, `ovf`, `carry_q`, `cnt` and the shift registers are all cleared to 0.
  - An aborted operation never produces `done`.
  - `start` sampled at the same edge as reset is ignored.

## Timing
- `start` is accepted at edge k, with the FSM in IDLE or DONE.
- `busy` = 1 during cycles k+1 … k+WIDTH, which is WIDTH cycles.
- `done` = 1 during the cycle after edge k+WIDTH. This is a latency of WIDTH+1 edges from start to `done`.
- `result`, `cout` and `ovf` are valid from the same cycle as `done`.
- If `start` is held at the DONE cycle, the next operation's RUN begins at the next edge. Throughput is one operation per WIDTH+1 cycles.
- There is no combinational path from inputs to outputs. All outputs are registered.
- Reset values of all outputs are 0: `busy`, `done`, `result`, `cout`, `ovf`.

## Test plan
- WIDTH = 8, add 0x35 + 0x4A → `result` = 0x7F, `cout` = 0, `ovf` = 0. `done` is high exactly 9 edges after the `start` edge, and `busy` is high for exactly 8 cycles.
- Add 0xFF + 0x01 → `result` = 0x00, `cout` = 1, `ovf` = 0. Then add 0x7F + 0x01 → `result` = 0x80, `cout` = 0, `ovf` = 1.
- Subtract (`sub` = 1):
  - 0x10 − 0x20 → 0xF0, `cout` = 0, `ovf` = 0.
  - 0x20 − 0x10 → 0x10, `cout` = 1.
  - 0x80 − 0x01 → 0x7F, `ovf` = 1.
- Pulse `start` with new operands 3 cycles into RUN → ignored. The first result is unchanged, there is one `done` only, and `result` holds its old value during RUN.
- Hold `start` at the DONE cycle with 0x01 + 0x02 → `done` pulses for 1 cycle. `busy` rises at the next edge, and 0x03 appears 9 edges after the second `start`.
- Drive `rst_n` = 0 at RUN cycle 4 → all outputs are 0 at the next cycle, the FSM is in IDLE, and no `done` occurs. A subsequent 0x35 + 0x4A still gives 0x7F.
